controlador_estados_pet: RTL and testbench

//  Pet behaviour FSM. Sits between the debounced button stage and controlador_imagens.

---
 rtl/controlador_estados_pet_pkg.sv | 34 +++
 rtl/controlador_estados_pet_if.sv | 29 ++
 rtl/controlador_estados_pet_divisor_tick.sv | 33 +++
 rtl/controlador_estados_pet.sv | 198 +++++++++++++++++++
 tb/tb_controlador_estados_pet.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/controlador_estados_pet_pkg.sv
// +--------------------------------------------------------------------+
// | pet_pkg: estado encodings, level limits and saturating level math. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package pet_pkg;

   typedef enum logic [3:0] {
      NORMAL    = 4'd0,
      COMENDO   = 4'd1,
      BRINCANDO = 4'd2,
      DORMINDO  = 4'd3,
      FAMINTO   = 4'd4,
      TRISTE    = 4'd5,
      MORTO     = 4'd6
   } estado_t;

   localparam int NIVEL_MAX  = 15;
   localparam int DELTA_ACAO = 4;

   // Clamps a signed net adjustment into the 0..NIVEL_MAX level range.
   function automatic logic [3:0] saturar(input int valor);
      if (valor < 0)
         return 4'd0;
      else if (valor > NIVEL_MAX)
         return 4'(NIVEL_MAX);
      else
         return 4'(valor);
   endfunction

endpackage

`default_nettype wire

// File: rtl/controlador_estados_pet_if.sv
// +--------------------------------------------------------------------+
// | controlador_estados_pet_if: button pulses in, pet status out.      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface controlador_estados_pet_if;

   logic       b_comer;
   logic       b_brincar;
   logic       b_dormir;
   logic [3:0] estado;
   logic [3:0] fome;
   logic [3:0] felicidade;
   logic       evento;

   modport master (
      output b_comer, b_brincar, b_dormir,
      input  estado, fome, felicidade, evento
   );

   modport slave (
      input  b_comer, b_brincar, b_dormir,
      output estado, fome, felicidade, evento
   );

endinterface

`default_nettype wire

// File: rtl/controlador_estados_pet_divisor_tick.sv
// +--------------------------------------------------------------------+
// | divisor_tick: free-running prescaler, one-clk tick at terminal.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module divisor_tick #(
   parameter int TICKS_POR_SEG = 27_000_000
)(
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int              CW         = (TICKS_POR_SEG > 1) ? $clog2(TICKS_POR_SEG) : 1;
   localparam logic [CW-1:0]   C_TERMINAL = CW'(TICKS_POR_SEG - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_cnt <= '0;
      else if (r_cnt == C_TERMINAL)
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + 1'b1;
   end

   assign tick = (r_cnt == C_TERMINAL);

endmodule

`default_nettype wire

// File: rtl/controlador_estados_pet.sv
// +--------------------------------------------------------------------+
// | controlador_estados_pet: pet behaviour FSM with 1 s aging.         |
// | Optional death state enabled by `define PET_MORTE_EN. Rev 1.0      |
// +--------------------------------------------------------------------+
`default_nettype none

module controlador_estados_pet
   import pet_pkg::*;
#(
   parameter int TICKS_POR_SEG = 27_000_000,
   parameter int FOME_PERIODO  = 10,
   parameter int TEDIO_PERIODO = 8,
   parameter int ACAO_SEG      = 3,
   parameter int SONO_SEG      = 8,
   parameter int LIMIAR_FOME   = 12,
   parameter int LIMIAR_TRISTE = 3
`ifdef PET_MORTE_EN
   ,
   parameter int MORTE_SEG     = 20
`endif
)(
   input  logic                     clk,
   input  logic                     rst,
   controlador_estados_pet_if.slave pet
);

   localparam int            FW          = $clog2(FOME_PERIODO + 1);
   localparam int            TW          = $clog2(TEDIO_PERIODO + 1);
   localparam int            AW          = $clog2(((ACAO_SEG > SONO_SEG) ? ACAO_SEG : SONO_SEG) + 1);
   localparam logic [FW-1:0] C_FOME_FIM  = FW'(FOME_PERIODO - 1);
   localparam logic [TW-1:0] C_TEDIO_FIM = TW'(TEDIO_PERIODO - 1);
   localparam logic [AW-1:0] C_ACAO_FIM  = AW'(ACAO_SEG - 1);
   localparam logic [AW-1:0] C_SONO_FIM  = AW'(SONO_SEG - 1);

   logic          w_tick;
   logic          w_vivo;
   logic          w_avaliar;
   int            w_delta_fome;
   int            w_delta_fel;

   estado_t       r_estado,      w_estado_n;
   logic [3:0]    r_fome,        w_fome_n;
   logic [3:0]    r_felicidade,  w_fel_n;
   logic          r_evento;
   logic [FW-1:0] r_cnt_fome,    w_cnt_fome_n;
   logic [TW-1:0] r_cnt_tedio,   w_cnt_tedio_n;
   logic [AW-1:0] r_timer,       w_timer_n;

`ifdef PET_MORTE_EN
   localparam int            MW          = $clog2(MORTE_SEG + 1);
   localparam logic [MW-1:0] C_MORTE_FIM = MW'(MORTE_SEG - 1);
   logic [MW-1:0] r_cnt_morte,   w_cnt_morte_n;
`endif

   divisor_tick #(
      .TICKS_POR_SEG (TICKS_POR_SEG)
   ) u_divisor_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (w_tick)
   );

   // Hunger dominates sadness.
   function automatic estado_t avaliar_humor(input logic [3:0] f, input logic [3:0] h);
      if (int'(f) >= LIMIAR_FOME)
         return FAMINTO;
      else if (int'(h) <= LIMIAR_TRISTE)
         return TRISTE;
      else
         return NORMAL;
   endfunction

   assign w_vivo = (r_estado != MORTO);

   always_comb begin
      w_estado_n    = r_estado;
      w_timer_n     = r_timer;
      w_cnt_fome_n  = r_cnt_fome;
      w_cnt_tedio_n = r_cnt_tedio;
      w_delta_fome  = 0;
      w_delta_fel   = 0;
      w_avaliar     = 1'b0;

      if (w_tick && w_vivo) begin
         if (r_cnt_fome == C_FOME_FIM) begin
            w_cnt_fome_n = '0;
            w_delta_fome = 1;
         end else begin
            w_cnt_fome_n = r_cnt_fome + 1'b1;
         end
         if (r_estado != DORMINDO) begin
            if (r_cnt_tedio == C_TEDIO_FIM) begin
               w_cnt_tedio_n = '0;
               w_delta_fel   = -1;
            end else begin
               w_cnt_tedio_n = r_cnt_tedio + 1'b1;
            end
         end
      end

      case (r_estado)
         NORMAL, FAMINTO, TRISTE: begin
            if (pet.b_comer) begin
               w_estado_n   = COMENDO;
               w_delta_fome = w_delta_fome - DELTA_ACAO;
               w_timer_n    = '0;
            end else if (pet.b_brincar) begin
               w_estado_n   = BRINCANDO;
               w_delta_fel  = w_delta_fel + DELTA_ACAO;
               w_timer_n    = '0;
            end else if (pet.b_dormir) begin
               w_estado_n   = DORMINDO;
               w_timer_n    = '0;
            end else begin
               w_avaliar    = 1'b1;
            end
         end
         COMENDO, BRINCANDO: begin
            if (w_tick) begin
               if (r_timer == C_ACAO_FIM)
                  w_avaliar = 1'b1;
               else
                  w_timer_n = r_timer + 1'b1;
            end
         end
         DORMINDO: begin
            if (pet.b_dormir) begin
               w_avaliar = 1'b1;
            end else if (w_tick) begin
               if (r_timer == C_SONO_FIM)
                  w_avaliar = 1'b1;
               else
                  w_timer_n = r_timer + 1'b1;
            end
         end
         default: ;
      endcase

      // Aging and button deltas combine before a single saturation.
      w_fome_n = saturar(int'(r_fome) + w_delta_fome);
      w_fel_n  = saturar(int'(r_felicidade) + w_delta_fel);

      if (w_avaliar)
         w_estado_n = avaliar_humor(w_fome_n, w_fel_n);

`ifdef PET_MORTE_EN
      w_cnt_morte_n = r_cnt_morte;
      if (r_fome != 4'(NIVEL_MAX)) begin
         w_cnt_morte_n = '0;
      end else if (w_tick && w_vivo) begin
         if (r_cnt_morte == C_MORTE_FIM) begin
            w_estado_n = MORTO;
            w_fome_n   = r_fome;
            w_fel_n    = r_felicidade;
         end else begin
            w_cnt_morte_n = r_cnt_morte + 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_estado     <= NORMAL;
         r_fome       <= 4'd0;
         r_felicidade <= 4'(NIVEL_MAX);
         r_evento     <= 1'b0;
         r_cnt_fome   <= '0;
         r_cnt_tedio  <= '0;
         r_timer      <= '0;
      end else begin
         r_estado     <= w_estado_n;
         r_fome       <= w_fome_n;
         r_felicidade <= w_fel_n;
         r_evento     <= (w_estado_n != r_estado);
         r_cnt_fome   <= w_cnt_fome_n;
         r_cnt_tedio  <= w_cnt_tedio_n;
         r_timer      <= w_timer_n;
      end
   end

`ifdef PET_MORTE_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_cnt_morte <= '0;
      else
         r_cnt_morte <= w_cnt_morte_n;
   end
`endif

   assign pet.estado     = r_estado;
   assign pet.fome       = r_fome;
   assign pet.felicidade = r_felicidade;
   assign pet.evento     = r_evento;

endmodule

`default_nettype wire

// File: tb/tb_controlador_estados_pet.sv
// +--------------------------------------------------------------------+
// | tb_controlador_estados_pet: directed bench, 4-clk tick, observation|
// | packed as {estado,fome,felicidade,evento}. Rev 1.0                 |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_controlador_estados_pet;

   logic        clk;
   logic        rst;
   int          e;
   int          checks;
   int          errors;
   logic [12:0] obs;
   logic [12:0] exp_v;

   controlador_estados_pet_if pet_bus ();

   controlador_estados_pet #(
      .TICKS_POR_SEG (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .pet (pet_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // e = number of active edges since reset release; tick n lands on edge 4n-1.
   always @(posedge clk) begin
      if (rst)
         e <= 0;
      else
         e <= e + 1;
   end

   function automatic logic [12:0] snap();
      return {pet_bus.estado, pet_bus.fome, pet_bus.felicidade, pet_bus.evento};
   endfunction

   // Park on the negedge after edge k.
   task automatic run_to(input int k);
      int guard;
      guard = 0;
      while (e < k + 1 && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 5000) begin
         checks++;
         errors++;
         $display("FAIL run_to_timeout edge=%0d got e=%0d", k, e);
      end
   endtask

   task automatic press_at(input int k, input logic c, input logic b, input logic d);
      run_to(k - 1);
      pet_bus.b_comer   = c;
      pet_bus.b_brincar = b;
      pet_bus.b_dormir  = d;
      run_to(k);
      pet_bus.b_comer   = 1'b0;
      pet_bus.b_brincar = 1'b0;
      pet_bus.b_dormir  = 1'b0;
   endtask

   task automatic do_reset();
      rst               = 1'b1;
      pet_bus.b_comer   = 1'b0;
      pet_bus.b_brincar = 1'b0;
      pet_bus.b_dormir  = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      exp_v = {4'd0, 4'd0, 4'd15, 1'b0};
      checks++; obs = snap();
      if (obs !== exp_v) begin errors++; $display("FAIL reset_held got %h want %h", obs, exp_v); end
      do_reset();
      checks++; obs = snap();
      if (obs !== exp_v) begin errors++; $display("FAIL reset_release got %h want %h", obs, exp_v); end
   endtask

   task automatic test_tick_period();
      run_to(30);
      exp_v = {4'd0, 4'd0, 4'd15, 1'b0};
      checks++; obs = snap();
      if (obs !== exp_v) begin errors++; $display("FAIL tick7 got %h want %h", obs, exp_v); end
      run_to(31);
      exp_v = {4'd0, 4'd0, 4'd14, 1'b0};
      checks++; obs = snap();
      if (obs !== exp_v) begin errors++; $display("FAIL tick8_fel got %h want %h", obs, exp_v); end
      run_to(38);
      checks++; obs = snap();
      if (obs !== exp_v) begin errors++; $display("FAIL tick9 got %h want %h", obs, exp_v); end
      run_to(39);
      exp_v = {4'd0, 4'd1, 4'd14, 1'b0};
      checks++; obs = snap();
      if (obs !== exp_v) begin errors++; $display("FAIL tick10_fome got %h want %h", obs, exp_v); end
   endtask

   task automatic test_mood();
      int pulses;
      run_to(382);
      exp_v = {4'd0, 4'd9, 4'd4, 1'b0};
      checks++; obs = snap();
      if (obs !== exp_v) begin errors++; $display("FAIL pre_triste got %h want %h", obs, exp_v); end
      run_to(383);
      exp_v = {4'd5, 4'd9, 4'd3, 1'b1};
      checks++; obs = snap();
      if (obs !== exp_v) begin errors++; $display("FAIL triste_entry got %h want %h", obs, exp_v); end
      run_to(384);
      exp_v = {4'd5, 4'd9, 4'd3, 1'b0};
      checks++; obs = snap();
      if (obs !== exp_v) begin errors++; $display("FAIL triste_hold got %h want %h", obs, exp_v); end
      press_at(385, 1'b0, 1'b1, 1'b0);
      exp_v = {4'd2, 4'd9, 4'd7, 1'b1};
      checks++; obs = snap();
      if (obs !== exp_v) begin errors++; $display("FAIL brincar got %h want %h", obs, exp_v); end
      run_to(394);
      exp_v = {4'd2, 4'd9, 4'd7, 1'b0};
      checks++; obs = snap();
      if (obs !== exp_v) begin errors++; $display("FAIL brincar_hold got %h want %h", obs, exp_v); end
      run_to(395);
      exp_v = {4'd0, 4'd9, 4'd7, 1'b1};
      checks++; obs = snap();
      if (obs !== exp_v) begin errors++; $display("FAIL brincar_end got %h want %h", obs, exp_v); end
      pulses = 0;
      for (int k = 396; k <= 478; k++) begin
         run_to(k);
         if (pet_bus.evento === 1'b1) pulses++;
      end
      run_to(479);
      exp_v = {4'd4, 4'd12, 4'd4, 1'b1};
      checks++; obs = snap();
      if (obs !== exp_v) begin errors++; $display("FAIL faminto_entry got %h want %h", obs, exp_v); end
      checks++;
      if (pulses !== 0) begin errors++; $display("FAIL evento_quiet got %0d want 0", pulses); end
      run_to(480);
      checks++;
      if (pet_bus.evento !== 1'b0) begin errors++; $display("FAIL evento_once got %b want 0", pet_bus.evento); end
   endtask

   task automatic test_prioridade();
      press_at(481, 1'b1, 1'b0, 1'b1);
      exp_v = {4'd1, 4'd8, 4'd4, 1'b1};
      checks++; obs = snap();
      if (obs !== exp_v) begin errors++; $display("FAIL comer_dormir got %h want %h", obs, exp_v); end
      press_at(485, 1'b0, 1'b1, 1'b0);
      exp_v = {4'd1, 4'd8, 4'd4, 1'b0};
      checks++; obs = snap();
      if (obs !== exp_v) begin errors++; $display("FAIL brincar_ignored got %h want %h", obs, exp_v); end
      run_to(490);
      checks++; obs = snap();
      if (obs !== exp_v) begin errors++; $display("FAIL comendo_hold got %h want %h", obs, exp_v); end
      run_to(491);
      exp_v = {4'd0, 4'd8, 4'd4, 1'b1};
      checks++; obs = snap();
      if (obs !== exp_v) begin errors++; $display("FAIL comendo_end got %h want %h", obs, exp_v); end
   endtask

   task automatic test_back_to_back_tick();
      run_to(511);
      exp_v = {4'd5, 4'd8, 4'd3, 1'b1};
      checks++; obs = snap();
      if (obs !== exp_v) begin errors++; $display("FAIL triste_again got %h want %h", obs, exp_v); end
      press_at(519, 1'b1, 1'b0, 1'b0);
      exp_v = {4'd1, 4'd5, 4'd3, 1'b1};
      checks++; obs = snap();
      if (obs !== exp_v) begin errors++; $display("FAIL comer_on_tick got %h want %h", obs, exp_v); end
      run_to(530);
      exp_v = {4'd1, 4'd5, 4'd3, 1'b0};
      checks++; obs = snap();
      if (obs !== exp_v) begin errors++; $display("FAIL entry_tick_uncounted got %h want %h", obs, exp_v); end
      run_to(531);
      exp_v = {4'd5, 4'd5, 4'd3, 1'b1};
      checks++; obs = snap();
      if (obs !== exp_v) begin errors++; $display("FAIL comendo_to_triste got %h want %h", obs, exp_v); end
   endtask

   task automatic test_dormir();
      do_reset();
      press_at(119, 1'b1, 1'b0, 1'b0);
      exp_v = {4'd1, 4'd0, 4'd12, 1'b1};
      checks++; obs = snap();
      if (obs !== exp_v) begin errors++; $display("FAIL sat_zero got %h want %h", obs, exp_v); end
      run_to(131);
      exp_v = {4'd0, 4'd0, 4'd11, 1'b1};
      checks++; obs = snap();
      if (obs !== exp_v) begin errors++; $display("FAIL pre_sleep got %h want %h", obs, exp_v); end
      press_at(133, 1'b0, 1'b0, 1'b1);
      exp_v = {4'd3, 4'd0, 4'd11, 1'b1};
      checks++; obs = snap();
      if (obs !== exp_v) begin errors++; $display("FAIL dormir got %h want %h", obs, exp_v); end
      press_at(141, 1'b1, 1'b0, 1'b0);
      exp_v = {4'd3, 4'd0, 4'd11, 1'b0};
      checks++; obs = snap();
      if (obs !== exp_v) begin errors++; $display("FAIL comer_asleep got %h want %h", obs, exp_v); end
      run_to(162);
      exp_v = {4'd3, 4'd1, 4'd11, 1'b0};
      checks++; obs = snap();
      if (obs !== exp_v) begin errors++; $display("FAIL sleep_aging got %h want %h", obs, exp_v); end
      run_to(163);
      exp_v = {4'd0, 4'd1, 4'd11, 1'b1};
      checks++; obs = snap();
      if (obs !== exp_v) begin errors++; $display("FAIL auto_wake got %h want %h", obs, exp_v); end
      run_to(164);
      exp_v = {4'd0, 4'd1, 4'd11, 1'b0};
      checks++; obs = snap();
      if (obs !== exp_v) begin errors++; $display("FAIL wake_quiet got %h want %h", obs, exp_v); end
      press_at(165, 1'b0, 1'b0, 1'b1);
      exp_v = {4'd3, 4'd1, 4'd11, 1'b1};
      checks++; obs = snap();
      if (obs !== exp_v) begin errors++; $display("FAIL dormir2 got %h want %h", obs, exp_v); end
      run_to(172);
      exp_v = {4'd3, 4'd1, 4'd11, 1'b0};
      checks++; obs = snap();
      if (obs !== exp_v) begin errors++; $display("FAIL sleep2_hold got %h want %h", obs, exp_v); end
      press_at(173, 1'b0, 1'b0, 1'b1);
      exp_v = {4'd0, 4'd1, 4'd11, 1'b1};
      checks++; obs = snap();
      if (obs !== exp_v) begin errors++; $display("FAIL manual_wake got %h want %h", obs, exp_v); end
   endtask

   task automatic test_fome_max();
      do_reset();
      run_to(599);
      exp_v = {4'd4, 4'd15, 4'd0, 1'b0};
      checks++; obs = snap();
      if (obs !== exp_v) begin errors++; $display("FAIL fome_sat got %h want %h", obs, exp_v); end
      run_to(678);
      checks++; obs = snap();
      if (obs !== exp_v) begin errors++; $display("FAIL fome_hold got %h want %h", obs, exp_v); end
      run_to(679);
`ifdef PET_MORTE_EN
      exp_v = {4'd6, 4'd15, 4'd0, 1'b1};
`else
      exp_v = {4'd4, 4'd15, 4'd0, 1'b0};
`endif
      checks++; obs = snap();
      if (obs !== exp_v) begin errors++; $display("FAIL morte_tick got %h want %h", obs, exp_v); end
      press_at(681, 1'b1, 1'b0, 1'b0);
`ifdef PET_MORTE_EN
      exp_v = {4'd6, 4'd15, 4'd0, 1'b0};
`else
      exp_v = {4'd1, 4'd11, 4'd0, 1'b1};
`endif
      checks++; obs = snap();
      if (obs !== exp_v) begin errors++; $display("FAIL after_morte_comer got %h want %h", obs, exp_v); end
      do_reset();
      exp_v = {4'd0, 4'd0, 4'd15, 1'b0};
      checks++; obs = snap();
      if (obs !== exp_v) begin errors++; $display("FAIL final_reset got %h want %h", obs, exp_v); end
   endtask

   initial begin
      checks            = 0;
      errors            = 0;
      rst               = 1'b1;
      pet_bus.b_comer   = 1'b0;
      pet_bus.b_brincar = 1'b0;
      pet_bus.b_dormir  = 1'b0;
      test_reset();
      test_tick_period();
      test_mood();
      test_prioridade();
      test_back_to_back_tick();
      test_dormir();
      test_fome_max();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
